// File: rtl/systolic_mm_sequencer.sv
// Command sequencer for the 2x2 systolic array: fetches K operand slices, runs one pass per slice, returns C.
// Optional RUN watchdog with ABORT state is enabled by defining SYSTOLIC_SEQ_TIMEOUT_EN.
module systolic_mm_sequencer #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ACCUM_WIDTH    = 64,
  parameter int unsigned K_MAX          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned KW             = $clog2(K_MAX + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [KW-1:0]          cmd_k_i,
  input  logic                   cmd_acc_i,
  input  logic                   opnd_valid_i,
  output logic                   opnd_ready_o,
  input  logic [DATA_WIDTH-1:0]  opnd_a0_i,
  input  logic [DATA_WIDTH-1:0]  opnd_a1_i,
  input  logic [DATA_WIDTH-1:0]  opnd_b0_i,
  input  logic [DATA_WIDTH-1:0]  opnd_b1_i,
  output logic                   arr_start_o,
  output logic                   arr_clear_o,
  output logic                   arr_accumulate_o,
  output logic [DATA_WIDTH-1:0]  arr_a_row0_o,
  output logic [DATA_WIDTH-1:0]  arr_a_row1_o,
  output logic [DATA_WIDTH-1:0]  arr_b_col0_o,
  output logic [DATA_WIDTH-1:0]  arr_b_col1_o,
  output logic                   arr_a_valid_o,
  output logic                   arr_b_valid_o,
  input  logic                   arr_busy_i,
  input  logic                   arr_done_i,
  input  logic [ACCUM_WIDTH-1:0] arr_c00_i,
  input  logic [ACCUM_WIDTH-1:0] arr_c01_i,
  input  logic [ACCUM_WIDTH-1:0] arr_c10_i,
  input  logic [ACCUM_WIDTH-1:0] arr_c11_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [ACCUM_WIDTH-1:0] res_c00_o,
  output logic [ACCUM_WIDTH-1:0] res_c01_o,
  output logic [ACCUM_WIDTH-1:0] res_c10_o,
  output logic [ACCUM_WIDTH-1:0] res_c11_o,
  output logic                   busy_o,
  output logic                   err_o
);

`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_START, S_RUN, S_OUTPUT, S_ABORT} state_e;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q, timer_d;
`else
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FETCH, S_START, S_RUN, S_OUTPUT} state_e;
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  logic unused_busy;
  assign unused_busy = arr_busy_i;

  state_e                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d, slice_q, slice_d;
  logic                   acc_q, acc_d;
  logic [DATA_WIDTH-1:0]  a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;
  logic [ACCUM_WIDTH-1:0] c00_q, c00_d, c01_q, c01_d, c10_q, c10_d, c11_q, c11_d;
  logic cmd_ready_q, cmd_ready_d, opnd_ready_q, opnd_ready_d, start_q, start_d;
  logic clear_q, clear_d, accum_q, accum_d, opvalid_q, opvalid_d;
  logic res_valid_q, res_valid_d, busy_q, busy_d, err_q, err_d;

  // Next-state, datapath capture and registered-output decode
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    slice_d = slice_q;
    a0_d = a0_q; a1_d = a1_q; b0_d = b0_q; b1_d = b1_q;
    c00_d = c00_q; c01_d = c01_q; c10_d = c10_q; c11_d = c11_q;
    err_d = 1'b0;
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
    timer_d = timer_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          k_d     = cmd_k_i;
          acc_d   = cmd_acc_i;
          slice_d = '0;
          if (cmd_k_i == '0 || cmd_k_i > KW'(K_MAX)) err_d = 1'b1;
          else state_d = cmd_acc_i ? S_FETCH : S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_FETCH;
      S_FETCH: begin
        if (opnd_valid_i && opnd_ready_q) begin
          a0_d = opnd_a0_i; a1_d = opnd_a1_i; b0_d = opnd_b0_i; b1_d = opnd_b1_i;
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_RUN;
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
        timer_d = '0;
`endif
      end
      S_RUN: begin
        if (arr_done_i) begin
          if (slice_q == k_q - KW'(1)) begin
            c00_d = arr_c00_i; c01_d = arr_c01_i; c10_d = arr_c10_i; c11_d = arr_c11_i;
            slice_d = '0;
            state_d = S_OUTPUT;
          end else begin
            slice_d = slice_q + KW'(1);
            state_d = S_FETCH;
          end
        end
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ABORT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end
      S_OUTPUT: if (res_ready_i && res_valid_q) state_d = S_IDLE;
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
      S_ABORT: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d  = (state_d == S_IDLE);
    opnd_ready_d = (state_d == S_FETCH);
    start_d      = (state_d == S_START);
    clear_d      = (state_d == S_CLEAR);
    opvalid_d    = (state_d == S_RUN);
    res_valid_d  = (state_d == S_OUTPUT);
    busy_d       = (state_d != S_IDLE);
    accum_d      = (slice_d != '0) || acc_d;
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
    if (state_d == S_ABORT) begin
      clear_d = 1'b1;
      err_d   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      k_q <= '0; acc_q <= 1'b0; slice_q <= '0;
      a0_q <= '0; a1_q <= '0; b0_q <= '0; b1_q <= '0;
      c00_q <= '0; c01_q <= '0; c10_q <= '0; c11_q <= '0;
      cmd_ready_q <= 1'b0; opnd_ready_q <= 1'b0; start_q <= 1'b0; clear_q <= 1'b0;
      accum_q <= 1'b0; opvalid_q <= 1'b0; res_valid_q <= 1'b0; busy_q <= 1'b0; err_q <= 1'b0;
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
      timer_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q <= k_d; acc_q <= acc_d; slice_q <= slice_d;
      a0_q <= a0_d; a1_q <= a1_d; b0_q <= b0_d; b1_q <= b1_d;
      c00_q <= c00_d; c01_q <= c01_d; c10_q <= c10_d; c11_q <= c11_d;
      cmd_ready_q <= cmd_ready_d; opnd_ready_q <= opnd_ready_d; start_q <= start_d;
      clear_q <= clear_d; accum_q <= accum_d; opvalid_q <= opvalid_d;
      res_valid_q <= res_valid_d; busy_q <= busy_d; err_q <= err_d;
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
      timer_q <= timer_d;
`endif
    end
  end

  assign cmd_ready_o      = cmd_ready_q;
  assign opnd_ready_o     = opnd_ready_q;
  assign arr_start_o      = start_q;
  assign arr_clear_o      = clear_q;
  assign arr_accumulate_o = accum_q;
  assign arr_a_row0_o     = a0_q;
  assign arr_a_row1_o     = a1_q;
  assign arr_b_col0_o     = b0_q;
  assign arr_b_col1_o     = b1_q;
  assign arr_a_valid_o    = opvalid_q;
  assign arr_b_valid_o    = opvalid_q;
  assign res_valid_o      = res_valid_q;
  assign res_c00_o        = c00_q;
  assign res_c01_o        = c01_q;
  assign res_c10_o        = c10_q;
  assign res_c11_o        = c11_q;
  assign busy_o           = busy_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_systolic_mm_sequencer.sv
// Self-checking bench: random commands against a 2x2 array model and a spec-level matrix-product reference.
module tb_systolic_mm_sequencer;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 64;
  localparam int unsigned KM = 16;
  localparam int unsigned TO = 8;
  localparam int unsigned KW = $clog2(KM + 1);

  logic clk = 1'b0;
  logic rst_i, cmd_valid_i, cmd_ready_o, cmd_acc_i, opnd_valid_i, opnd_ready_o;
  logic [KW-1:0] cmd_k_i;
  logic [DW-1:0] opnd_a0_i, opnd_a1_i, opnd_b0_i, opnd_b1_i;
  logic arr_start_o, arr_clear_o, arr_accumulate_o, arr_a_valid_o, arr_b_valid_o;
  logic [DW-1:0] arr_a_row0_o, arr_a_row1_o, arr_b_col0_o, arr_b_col1_o;
  logic arr_busy_i, arr_done_i;
  logic [AW-1:0] arr_c00_i, arr_c01_i, arr_c10_i, arr_c11_i;
  logic res_valid_o, res_ready_i, busy_o, err_o;
  logic [AW-1:0] res_c00_o, res_c01_o, res_c10_o, res_c11_o;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] arr_mem [4];

  always #5 clk = ~clk;

  systolic_mm_sequencer #(.DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .K_MAX(KM), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_k_i(cmd_k_i), .cmd_acc_i(cmd_acc_i),
    .opnd_valid_i(opnd_valid_i), .opnd_ready_o(opnd_ready_o),
    .opnd_a0_i(opnd_a0_i), .opnd_a1_i(opnd_a1_i), .opnd_b0_i(opnd_b0_i), .opnd_b1_i(opnd_b1_i),
    .arr_start_o(arr_start_o), .arr_clear_o(arr_clear_o), .arr_accumulate_o(arr_accumulate_o),
    .arr_a_row0_o(arr_a_row0_o), .arr_a_row1_o(arr_a_row1_o),
    .arr_b_col0_o(arr_b_col0_o), .arr_b_col1_o(arr_b_col1_o),
    .arr_a_valid_o(arr_a_valid_o), .arr_b_valid_o(arr_b_valid_o),
    .arr_busy_i(arr_busy_i), .arr_done_i(arr_done_i),
    .arr_c00_i(arr_c00_i), .arr_c01_i(arr_c01_i), .arr_c10_i(arr_c10_i), .arr_c11_i(arr_c11_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_c00_o(res_c00_o), .res_c01_o(res_c01_o), .res_c10_o(res_c10_o), .res_c11_o(res_c11_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ctrl_vec();
    return {cmd_ready_o, opnd_ready_o, arr_start_o, arr_clear_o, arr_accumulate_o,
            arr_a_valid_o, arr_b_valid_o, res_valid_o, busy_o, err_o};
  endfunction

  function automatic logic [255:0] res_vec();
    return {res_c00_o, res_c01_o, res_c10_o, res_c11_o};
  endfunction

  // One command end to end; the bench plays operand source, array and result sink.
  // rst_pass >= 0 asserts reset in the first RUN cycle of that pass; exp_abort expects the watchdog.
  task automatic run_cmd(input int k, input bit acc, input int p, input int opnd_stall,
                         input int res_stall, input bit fixed, input int rst_pass, input bit exp_abort);
    logic [127:0] ops [$];
    logic [AW-1:0] exp [4];
    logic [AW-1:0] pr [4];
    logic [255:0] first_res;
    logic [15:0] seen_acc, exp_acc;
    int nclr = 0, nstart = 0, ndone = 0, idx = 0, j = 0, lat = 0, viol = 0, runcyc = 0;
    bit fin = 0, got = 0, aborted = 0;
    seen_acc = '0;
    exp_acc  = '0;
    first_res = '0;
    for (int i = 0; i < 4; i++) exp[i] = acc ? arr_mem[i] : '0;
    for (int s = 0; s < k; s++) begin
      logic [DW-1:0] a0, a1, b0, b1;
      if (fixed) begin a0 = 2; a1 = 3; b0 = 4; b1 = 5; end
      else begin a0 = $urandom; a1 = $urandom; b0 = $urandom; b1 = $urandom; end
      ops.push_back({a0, a1, b0, b1});
      exp[0] += AW'(a0) * AW'(b0);
      exp[1] += AW'(a0) * AW'(b1);
      exp[2] += AW'(a1) * AW'(b0);
      exp[3] += AW'(a1) * AW'(b1);
      exp_acc[s] = (s > 0) || acc;
    end
    @(negedge clk);
    chk("cmd_ready_idle", 256'(cmd_ready_o), 256'(1));
    cmd_valid_i = 1'b1; cmd_k_i = KW'(k); cmd_acc_i = acc;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      arr_done_i = 1'b0;
      if (arr_clear_o) begin nclr++; for (int i = 0; i < 4; i++) arr_mem[i] = '0; end
      if (arr_start_o) begin
        if (nstart < 16) seen_acc[nstart] = arr_accumulate_o;
        nstart++; j = 0;
      end
      if (busy_o && cmd_ready_o) viol++;
      if (err_o) begin
        aborted = 1;
        fin = 1;
        chk("err_clear", 256'(arr_clear_o), 256'(exp_abort));
        if (exp_abort) chk("abort_run_cycles", 256'(runcyc), 256'(TO));
      end
      if (!fin && arr_a_valid_o && arr_b_valid_o) begin
        runcyc++;
        if (rst_pass >= 0 && nstart == rst_pass + 1) begin
          rst_i = 1'b1; opnd_valid_i = 1'b0; res_ready_i = 1'b0;
          @(negedge clk);
          chk("rst_ctrl", 256'(ctrl_vec()), 256'(0));
          chk("rst_ops", 256'({arr_a_row0_o, arr_a_row1_o, arr_b_col0_o, arr_b_col1_o}), 256'(0));
          chk("rst_res", res_vec(), 256'(0));
          rst_i = 1'b0;
          @(negedge clk);
          chk("post_rst_ready", 256'({cmd_ready_o, busy_o}), 256'(2'b10));
          return;
        end
        j++;
        if (j == p) begin
          logic [DW-1:0] x0, x1, y0, y1;
          x0 = arr_a_row0_o; x1 = arr_a_row1_o; y0 = arr_b_col0_o; y1 = arr_b_col1_o;
          if (nstart > 0 && nstart <= k) chk("pass_ops", 256'({x0, x1, y0, y1}), 256'(ops[nstart-1]));
          pr[0] = AW'(x0) * AW'(y0); pr[1] = AW'(x0) * AW'(y1);
          pr[2] = AW'(x1) * AW'(y0); pr[3] = AW'(x1) * AW'(y1);
          for (int i = 0; i < 4; i++) arr_mem[i] = arr_accumulate_o ? arr_mem[i] + pr[i] : pr[i];
          arr_done_i = 1'b1;
          ndone++;
        end
      end
      arr_c00_i = arr_mem[0]; arr_c01_i = arr_mem[1]; arr_c10_i = arr_mem[2]; arr_c11_i = arr_mem[3];
      opnd_valid_i = 1'b0;
      if (!fin && opnd_ready_o) begin
        if (opnd_stall > 0) opnd_stall--;
        else if (idx < k) begin
          {opnd_a0_i, opnd_a1_i, opnd_b0_i, opnd_b1_i} = ops[idx];
          opnd_valid_i = 1'b1;
          idx++;
        end
      end
      res_ready_i = 1'b0;
      if (!fin && res_valid_o) begin
        if (!got) begin
          got = 1;
          first_res = res_vec();
          chk("dones_before_res", 256'(ndone), 256'(k));
          if (opnd_stall == 0 && res_stall >= 0 && idx == k && p > 0 && fixed == 0 && k < 0) ;
        end else if (res_vec() !== first_res) viol++;
        if (res_stall > 0) res_stall--;
        else begin res_ready_i = 1'b1; fin = 1; end
      end
      if (!got) lat++;
      @(negedge clk);
    end
    res_ready_i = 1'b0;
    opnd_valid_i = 1'b0;
    if (!fin) chk("cycle_budget", 256'(0), 256'(1));
    chk("abort_seen", 256'(aborted), 256'(exp_abort));
    chk("clear_pulses", 256'(nclr), 256'(acc ? 0 : 1));
    if (!exp_abort) begin
      chk("start_pulses", 256'(nstart), 256'(k));
      chk("accum_per_pass", 256'(seen_acc), 256'(exp_acc));
      chk("result", first_res, {exp[0], exp[1], exp[2], exp[3]});
      chk("stable_and_ready_low", 256'(viol), 256'(0));
    end
    chk("back_to_idle", 256'({cmd_ready_o, res_valid_o, busy_o}), 256'(3'b100));
  endtask

  // Latency-only variant: no stalls, measures accept-to-res_valid cycles.
  task automatic run_latency(input int k, input bit acc, input int p);
    int lat = 0, j = 0, nstart = 0;
    bit got = 0;
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_k_i = KW'(k); cmd_acc_i = acc;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    for (int cyc = 0; cyc < 2000 && !got; cyc++) begin
      arr_done_i = 1'b0;
      opnd_valid_i = opnd_ready_o;
      if (arr_start_o) begin j = 0; nstart++; end
      if (arr_a_valid_o) begin j++; if (j == p) arr_done_i = 1'b1; end
      if (arr_clear_o) for (int i = 0; i < 4; i++) arr_mem[i] = '0;
      if (res_valid_o) got = 1;
      else begin lat++; @(negedge clk); end
    end
    chk("latency", 256'(lat), 256'(acc ? k * (p + 2) : 1 + k * (p + 2)));
    res_ready_i = 1'b1; opnd_valid_i = 1'b0;
    @(negedge clk);
    res_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) arr_mem[i] = 'x;
    for (int i = 0; i < 4; i++) arr_mem[i] = '0;
  endtask

  task automatic bad_cmd(input int k);
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_k_i = KW'(k); cmd_acc_i = 1'b0;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("bad_k_err", 256'({err_o, cmd_ready_o, busy_o, arr_start_o, arr_clear_o}), 256'(5'b11000));
    @(negedge clk);
    chk("bad_k_err_pulse", 256'({err_o, cmd_ready_o, busy_o, arr_start_o}), 256'(4'b0100));
  endtask

  initial begin
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_k_i = '0; cmd_acc_i = 1'b0; opnd_valid_i = 1'b0;
    opnd_a0_i = '0; opnd_a1_i = '0; opnd_b0_i = '0; opnd_b1_i = '0;
    arr_busy_i = 1'b0; arr_done_i = 1'b0; res_ready_i = 1'b0;
    arr_c00_i = '0; arr_c01_i = '0; arr_c10_i = '0; arr_c11_i = '0;
    for (int i = 0; i < 4; i++) arr_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 256'(ctrl_vec()), 256'(0));
    chk("reset_res", res_vec(), 256'(0));
    rst_i = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 256'({cmd_ready_o, busy_o}), 256'(2'b10));

    run_cmd(1, 1'b0, 3, 0, 0, 1'b1, -1, 1'b0);
    chk("k1_c00", 256'(res_c00_o), 256'(8));
    chk("k1_c11", 256'(res_c11_o), 256'(15));
    run_cmd(3, 1'b0, 2, 0, 0, 1'b0, -1, 1'b0);
    run_cmd(2, 1'b1, 4, 0, 0, 1'b0, -1, 1'b0);
    bad_cmd(0);
    bad_cmd(17);
    run_cmd(2, 1'b0, 2, 4, 5, 1'b0, -1, 1'b0);
    run_cmd(3, 1'b0, 3, 0, 0, 1'b0, 1, 1'b0);
    run_cmd(2, 1'b1, 2, 0, 0, 1'b0, -1, 1'b0);
    run_latency(3, 1'b0, 3);
    run_latency(2, 1'b1, 1);
    run_cmd(16, 1'b0, 1, 0, 0, 1'b0, -1, 1'b0);
    for (int n = 0; n < 6; n++)
      run_cmd($urandom_range(1, 16), 1'($urandom_range(0, 1)), $urandom_range(1, 4),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, -1, 1'b0);
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
    run_cmd(1, 1'b1, 0, 0, 0, 1'b0, -1, 1'b1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
